// File: rtl/tangram_pkg.sv
// Shared definitions for the tangram key control slice.
// Holds the move-direction bit positions, the piece count, the default timing
// constants for a 40 MHz clock, the auto-repeat state encoding and a small
// wrap-around increment helper for the piece index.
package tangram_pkg;

    // Bit positions inside the one-hot move strobe
    localparam int MV_UP    = 0;
    localparam int MV_DOWN  = 1;
    localparam int MV_LEFT  = 2;
    localparam int MV_RIGHT = 3;

    localparam int NUM_PIECES = 7;

    // Default timing at 40 MHz: 20 ms debounce, 0.4 s repeat delay, 50 ms repeat period
    localparam int DEF_DEB_CYCLES     = 800000;
    localparam int DEF_REPEAT_DELAY   = 16000000;
    localparam int DEF_REPEAT_PERIOD  = 2000000;
    localparam int DEF_KEY_ACTIVE_LOW = 1;

    typedef enum logic [1:0] {
        RP_IDLE   = 2'd0,
        RP_DELAY  = 2'd1,
        RP_REPEAT = 2'd2
    } rp_state_e;

    // Increment a piece index, wrapping to 0 once the last piece is reached
    function automatic logic [2:0] wrap_inc(input logic [2:0] idx, input logic [2:0] last);
        logic [2:0] nxt;
        if (idx >= last) begin
            nxt = 3'd0;
        end else begin
            nxt = idx + 3'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/tangram_key_debounce.sv
// Single-key conditioning: 2-FF synchronizer, polarity normalisation to
// active-high "pressed", counter debounce, rising-edge press detect and an
// optional auto-repeat FSM.
// Ports:
//   clk_40m  - system clock
//   rst_n    - asynchronous active-low reset
//   key_raw  - raw asynchronous button level
//   evt      - one-cycle event (press, or auto-repeat tick when REPEAT_EN=1);
//              decoded from registers, registered again by the caller
module tangram_key_debounce
    import tangram_pkg::*;
#(
    parameter int DEB_CYCLES     = DEF_DEB_CYCLES,
    parameter int REPEAT_DELAY   = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD  = DEF_REPEAT_PERIOD,
    parameter int KEY_ACTIVE_LOW = DEF_KEY_ACTIVE_LOW,
    parameter int REPEAT_EN      = 0
) (
    input  logic clk_40m,
    input  logic rst_n,
    input  logic key_raw,
    output logic evt
);

    localparam int DEB_W  = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int RP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RP_W   = (RP_MAX > 1) ? $clog2(RP_MAX) : 1;

    localparam logic [DEB_W-1:0] DEB_LAST   = DEB_W'(DEB_CYCLES - 1);
    localparam logic [RP_W-1:0]  DELAY_LAST = RP_W'(REPEAT_DELAY - 1);
    localparam logic [RP_W-1:0]  PER_LAST   = RP_W'(REPEAT_PERIOD - 1);
    // Raw level of a released key; the synchronizer resets to it so a key held
    // through reset is seen as a fresh press and must be re-debounced
    localparam logic REL_LVL = (KEY_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

    logic             sync1_r;
    logic             sync2_r;
    logic             level_r;
    logic             level_d_r;
    logic [DEB_W-1:0] deb_cnt_r;
    rp_state_e        rp_state_r;
    logic [RP_W-1:0]  rp_cnt_r;

    logic pressed_s;
    logic press_s;
    logic rp_pulse_s;

    assign pressed_s = (KEY_ACTIVE_LOW != 0) ? ~sync2_r : sync2_r;
    assign press_s   = level_r & ~level_d_r;
    assign evt       = press_s | rp_pulse_s;

    // Two-flop synchronizer for the asynchronous button
    always_ff @(posedge clk_40m or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= REL_LVL;
            sync2_r <= REL_LVL;
        end else begin
            sync1_r <= key_raw;
            sync2_r <= sync1_r;
        end
    end

    // Debounce: accept a new level only after it has persisted DEB_CYCLES cycles
    always_ff @(posedge clk_40m or negedge rst_n) begin
        if (!rst_n) begin
            level_r   <= 1'b0;
            level_d_r <= 1'b0;
            deb_cnt_r <= '0;
        end else begin
            level_d_r <= level_r;
            if (pressed_s == level_r) begin
                deb_cnt_r <= '0;
            end else if (deb_cnt_r == DEB_LAST) begin
                level_r   <= pressed_s;
                deb_cnt_r <= '0;
            end else begin
                deb_cnt_r <= deb_cnt_r + DEB_W'(1);
            end
        end
    end

    // Repeat tick decode; a tick is suppressed once the accepted level has dropped
    always_comb begin
        rp_pulse_s = 1'b0;
        case (rp_state_r)
            RP_DELAY:  rp_pulse_s = level_r && (rp_cnt_r == DELAY_LAST);
            RP_REPEAT: rp_pulse_s = level_r && (rp_cnt_r == PER_LAST);
            default:   rp_pulse_s = 1'b0;
        endcase
    end

    // Auto-repeat FSM; stays in RP_IDLE for keys built without repeat
    always_ff @(posedge clk_40m or negedge rst_n) begin
        if (!rst_n) begin
            rp_state_r <= RP_IDLE;
            rp_cnt_r   <= '0;
        end else begin
            case (rp_state_r)
                RP_IDLE: begin
                    rp_cnt_r <= '0;
                    if (press_s && (REPEAT_EN != 0)) begin
                        rp_state_r <= RP_DELAY;
                    end else begin
                        rp_state_r <= RP_IDLE;
                    end
                end
                RP_DELAY: begin
                    if (!level_r) begin
                        rp_state_r <= RP_IDLE;
                        rp_cnt_r   <= '0;
                    end else if (rp_cnt_r == DELAY_LAST) begin
                        rp_state_r <= RP_REPEAT;
                        rp_cnt_r   <= '0;
                    end else begin
                        rp_cnt_r <= rp_cnt_r + RP_W'(1);
                    end
                end
                RP_REPEAT: begin
                    if (!level_r) begin
                        rp_state_r <= RP_IDLE;
                        rp_cnt_r   <= '0;
                    end else if (rp_cnt_r == PER_LAST) begin
                        rp_cnt_r <= '0;
                    end else begin
                        rp_cnt_r <= rp_cnt_r + RP_W'(1);
                    end
                end
                default: begin
                    rp_state_r <= RP_IDLE;
                    rp_cnt_r   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/tangram_key_ctrl.sv
// Upstream control for the tangram shape renderers: six debounced buttons
// become a one-hot piece select, a one-cycle rotate strobe and a one-hot,
// one-cycle move strobe with auto-repeat on the four direction keys.
// Ports:
//   clk_40m   - 40 MHz clock
//   rst_n     - asynchronous active-low reset
//   key_up/key_down/key_left/key_right/key_rot/key_sel - raw buttons
//   select    - one-hot enable of the controlled piece
//   sel_idx   - binary index of the controlled piece
//   rotate    - one-cycle rotate strobe
//   move      - one-hot one-cycle move strobe (0 up, 1 down, 2 left, 3 right)
module tangram_key_ctrl
    import tangram_pkg::*;
#(
    parameter int DEB_CYCLES     = DEF_DEB_CYCLES,
    parameter int REPEAT_DELAY   = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD  = DEF_REPEAT_PERIOD,
    parameter int KEY_ACTIVE_LOW = DEF_KEY_ACTIVE_LOW,
    parameter int NUM_PIECES     = tangram_pkg::NUM_PIECES
) (
    input  logic                  clk_40m,
    input  logic                  rst_n,
    input  logic                  key_up,
    input  logic                  key_down,
    input  logic                  key_left,
    input  logic                  key_right,
    input  logic                  key_rot,
    input  logic                  key_sel,
    output logic [NUM_PIECES-1:0] select,
    output logic [2:0]            sel_idx,
    output logic                  rotate,
    output logic [3:0]            move
);

    localparam int KEY_ROT = 4;
    localparam int KEY_SEL = 5;
    localparam logic [NUM_PIECES-1:0] PIECE0     = {{(NUM_PIECES-1){1'b0}}, 1'b1};
    localparam logic [2:0]            LAST_PIECE = 3'(NUM_PIECES - 1);

    logic [5:0]            keys_s;
    logic [5:0]            evt_s;
    logic [3:0]            move_nxt_s;
    logic                  rotate_nxt_s;
    logic [2:0]            sel_idx_nxt_s;
    logic [NUM_PIECES-1:0] select_nxt_s;

    logic [NUM_PIECES-1:0] select_r;
    logic [2:0]            sel_idx_r;
    logic                  rotate_r;
    logic [3:0]            move_r;

    // Index 0..3 line up with the move bit positions
    assign keys_s = {key_sel, key_rot, key_right, key_left, key_down, key_up};

    for (genvar i = 0; i < 6; i++) begin : g_key
        tangram_key_debounce #(
            .DEB_CYCLES    (DEB_CYCLES),
            .REPEAT_DELAY  (REPEAT_DELAY),
            .REPEAT_PERIOD (REPEAT_PERIOD),
            .KEY_ACTIVE_LOW(KEY_ACTIVE_LOW),
            .REPEAT_EN     ((i < 4) ? 1 : 0)
        ) u_key (
            .clk_40m(clk_40m),
            .rst_n  (rst_n),
            .key_raw(keys_s[i]),
            .evt    (evt_s[i])
        );
    end

    // Arbitration, select advance and the sel collision blanking
    always_comb begin
        move_nxt_s    = 4'b0000;
        rotate_nxt_s  = evt_s[KEY_ROT];
        sel_idx_nxt_s = sel_idx_r;
        select_nxt_s  = select_r;
        // Fixed priority; losing directions in the same cycle are dropped
        if (evt_s[MV_UP]) begin
            move_nxt_s[MV_UP] = 1'b1;
        end else if (evt_s[MV_DOWN]) begin
            move_nxt_s[MV_DOWN] = 1'b1;
        end else if (evt_s[MV_LEFT]) begin
            move_nxt_s[MV_LEFT] = 1'b1;
        end else if (evt_s[MV_RIGHT]) begin
            move_nxt_s[MV_RIGHT] = 1'b1;
        end else begin
            move_nxt_s = 4'b0000;
        end
        // A piece switch blanks this cycle's steps so neither piece receives a stray one
        if (evt_s[KEY_SEL]) begin
            sel_idx_nxt_s = wrap_inc(sel_idx_r, LAST_PIECE);
            select_nxt_s  = PIECE0 << sel_idx_nxt_s;
            move_nxt_s    = 4'b0000;
            rotate_nxt_s  = 1'b0;
        end else begin
            sel_idx_nxt_s = sel_idx_r;
            select_nxt_s  = select_r;
        end
    end

    // Output registers
    always_ff @(posedge clk_40m or negedge rst_n) begin
        if (!rst_n) begin
            select_r  <= PIECE0;
            sel_idx_r <= 3'd0;
            rotate_r  <= 1'b0;
            move_r    <= 4'b0000;
        end else begin
            select_r  <= select_nxt_s;
            sel_idx_r <= sel_idx_nxt_s;
            rotate_r  <= rotate_nxt_s;
            move_r    <= move_nxt_s;
        end
    end

    assign select  = select_r;
    assign sel_idx = sel_idx_r;
    assign rotate  = rotate_r;
    assign move    = move_r;

endmodule

// File: tb/tb_tangram_key_ctrl.sv
// Directed bench for tangram_key_ctrl with short timing (debounce 4,
// repeat delay 20, repeat period 5, active-low keys). Strobes are logged
// with a cycle stamp on each falling edge and compared against hand-derived
// times: a raw change driven when the stamp reads t shows at output t+7.
module tb_tangram_key_ctrl;

    logic       clk_40m = 1'b0;
    logic       rst_n;
    logic       key_up, key_down, key_left, key_right, key_rot, key_sel;
    logic [6:0] select;
    logic [2:0] sel_idx;
    logic       rotate;
    logic [3:0] move;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int multi_hot = 0;

    int         mv_t[$];
    logic [3:0] mv_v[$];
    int         rot_t[$];

    tangram_key_ctrl #(
        .DEB_CYCLES    (4),
        .REPEAT_DELAY  (20),
        .REPEAT_PERIOD (5),
        .KEY_ACTIVE_LOW(1),
        .NUM_PIECES    (7)
    ) dut (
        .clk_40m  (clk_40m),
        .rst_n    (rst_n),
        .key_up   (key_up),
        .key_down (key_down),
        .key_left (key_left),
        .key_right(key_right),
        .key_rot  (key_rot),
        .key_sel  (key_sel),
        .select   (select),
        .sel_idx  (sel_idx),
        .rotate   (rotate),
        .move     (move)
    );

    always #5 clk_40m = ~clk_40m;

    // Cycle stamp, advanced on every rising edge
    always @(posedge clk_40m) begin
        cyc <= cyc + 1;
    end

    // Strobe logger, sampled away from the active edge
    always @(negedge clk_40m) begin
        if (move != 4'b0000) begin
            mv_t.push_back(cyc);
            mv_v.push_back(move);
            if ($countones(move) > 1) begin
                multi_hot <= multi_hot + 1;
            end
        end
        if (rotate) begin
            rot_t.push_back(cyc);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk_40m);
    endtask

    task automatic clear_log();
        mv_t.delete();
        mv_v.delete();
        rot_t.delete();
    endtask

    function automatic int mv_t_at(input int i);
        return (i < mv_t.size()) ? mv_t[i] : -1;
    endfunction

    function automatic logic [3:0] mv_v_at(input int i);
        return (i < mv_v.size()) ? mv_v[i] : 4'hf;
    endfunction

    initial begin
        int         t0;
        int         p0;
        int         rep_off[9];
        logic [6:0] exp_sel;
        logic [2:0] exp_idx;

        rep_off = '{0, 20, 25, 30, 35, 40, 45, 50, 55};

        // Reset with key_up already held down
        rst_n = 1'b0;
        key_up = 1'b0; key_down = 1'b1; key_left = 1'b1;
        key_right = 1'b1; key_rot = 1'b1; key_sel = 1'b1;
        step(5);
        check_eq("rst_sel_idx", 32'(sel_idx), 32'd0);
        check_eq("rst_select", 32'(select), 32'h01);
        check_eq("rst_move", 32'(move), 32'd0);
        check_eq("rst_rotate", 32'(rotate), 32'd0);
        clear_log();
        rst_n = 1'b1;
        t0 = cyc;
        step(15);
        key_up = 1'b1;
        step(20);
        check_eq("rst_up_count", 32'(mv_t.size()), 32'd1);
        check_eq("rst_up_time", 32'(mv_t_at(0)), 32'(t0 + 7));
        check_eq("rst_up_val", 32'(mv_v_at(0)), 32'h1);

        // Bounce on key_left: 2-cycle glitches, then a clean hold
        clear_log();
        for (int i = 0; i < 7; i++) begin
            key_left = 1'b0;
            step(2);
            key_left = 1'b1;
            step(2);
        end
        key_left = 1'b0;
        t0 = cyc;
        step(12);
        key_left = 1'b1;
        step(20);
        check_eq("bounce_count", 32'(mv_t.size()), 32'd1);
        check_eq("bounce_time", 32'(mv_t_at(0)), 32'(t0 + 7));
        check_eq("bounce_val", 32'(mv_v_at(0)), 32'h4);

        // Auto-repeat on key_right, released so the t=55 tick is the last
        clear_log();
        key_right = 1'b0;
        t0 = cyc;
        p0 = t0 + 7;
        step(57);
        key_right = 1'b1;
        step(40);
        check_eq("repeat_count", 32'(mv_t.size()), 32'd9);
        for (int i = 0; i < 9; i++) begin
            check_eq($sformatf("repeat_time%0d", i), 32'(mv_t_at(i)), 32'(p0 + rep_off[i]));
            check_eq($sformatf("repeat_val%0d", i), 32'(mv_v_at(i)), 32'h8);
        end

        // Down and right together: down wins, right is dropped
        clear_log();
        key_down = 1'b0;
        key_right = 1'b0;
        t0 = cyc;
        step(10);
        key_down = 1'b1;
        key_right = 1'b1;
        step(30);
        check_eq("prio_count", 32'(mv_t.size()), 32'd1);
        check_eq("prio_time", 32'(mv_t_at(0)), 32'(t0 + 7));
        check_eq("prio_val", 32'(mv_v_at(0)), 32'h2);

        // Seven select presses wrap 1..6 then 0; rotate collides with the 3rd
        clear_log();
        for (int i = 1; i <= 7; i++) begin
            key_sel = 1'b0;
            if (i == 3) begin
                key_rot = 1'b0;
            end
            step(6);
            if (i == 1) begin
                check_eq("sel_before_latency", 32'(sel_idx), 32'd0);
            end
            step(1);
            exp_idx = 3'(i % 7);
            exp_sel = 7'b0000001 << exp_idx;
            check_eq($sformatf("sel_idx_%0d", i), 32'(sel_idx), 32'(exp_idx));
            check_eq($sformatf("select_%0d", i), 32'(select), 32'(exp_sel));
            step(3);
            key_sel = 1'b1;
            key_rot = 1'b1;
            step(12);
        end
        check_eq("sel_collision_rotate", 32'(rot_t.size()), 32'd0);
        check_eq("sel_no_move", 32'(mv_t.size()), 32'd0);

        // Long rotate hold: exactly one strobe
        clear_log();
        key_rot = 1'b0;
        t0 = cyc;
        step(100);
        key_rot = 1'b1;
        step(20);
        check_eq("rot_count", 32'(rot_t.size()), 32'd1);
        check_eq("rot_time", 32'((rot_t.size() > 0) ? rot_t[0] : -1), 32'(t0 + 7));
        check_eq("rot_no_move", 32'(mv_t.size()), 32'd0);
        check_eq("rot_keeps_sel", 32'(sel_idx), 32'd0);

        check_eq("move_onehot", 32'(multi_hot), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/tangram_key_ctrl.md
Name: tangram_key_ctrl

Overview:
- Upstream control stage for the tangram shape renderers.
- Turns six raw board push-buttons into clean per-piece control: a one-hot piece select, single-cycle rotate pulses, and single-cycle one-hot move pulses.
- Each shape instance advances its position or rotation on every cycle its strobe is high, so the strobes must be exactly one clock wide and rate-limited. This block guarantees that.

Parameters:
- DEB_CYCLES, 800000: cycles a synchronized key must hold a new level before it is accepted (20 ms at 40 MHz).
- REPEAT_DELAY, 16000000: hold time after a move press before auto-repeat starts (0.4 s).
- REPEAT_PERIOD, 2000000: auto-repeat interval while a move key stays held (50 ms).
- KEY_ACTIVE_LOW, 1: 1 means raw key inputs read 0 when pressed.
- NUM_PIECES, 7: number of pieces cycled by the select key.

Ports:
- clk_40m  in  1  system/pixel clock, 40 MHz.
- rst_n  in  1  asynchronous active-low reset.
- key_up  in  1  raw, asynchronous button.
- key_down  in  1  raw button.
- key_left  in  1  raw button.
- key_right  in  1  raw button.
- key_rot  in  1  raw button.
- key_sel  in  1  raw button.
- select  out  NUM_PIECES  one-hot enable of the currently controlled piece.
- sel_idx  out  3  binary index of the current piece.
- rotate  out  1  one-cycle rotate strobe.
- move  out  4  one-hot, one-cycle move strobe: bit0 up, bit1 down, bit2 left, bit3 right.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low, clock port clk_40m, reset port rst_n.
  - rst_n low sets sel_idx=0, select=1 (piece 0), rotate=0, move=0.
  - All debounced levels are set to "released"; all counters and repeat FSMs are cleared.
  - Reset asserted mid-hold discards the hold. After release, a key already held must be re-debounced (DEB_CYCLES) before it generates a pulse.
- Input path:
  - Each key passes through a 2-FF synchronizer.
  - It is then normalised to active-high pressed according to KEY_ACTIVE_LOW.
- Debounce (per key):
  - The counter resets whenever the synchronized level equals the accepted level.
  - Otherwise it increments. On reaching DEB_CYCLES-1 the accepted level flips and the counter clears.
  - Glitches shorter than DEB_CYCLES never change the accepted level.
- Press event: a one-cycle pulse on the cycle after the accepted level rises. Releases generate nothing.
- Auto-repeat (move keys only), per-key FSM:
  - IDLE -> DELAY on the press event; the initial pulse is emitted.
  - DELAY -> REPEAT after REPEAT_DELAY cycles held; emits a pulse.
  - In REPEAT, a pulse is emitted every REPEAT_PERIOD cycles.
  - Any state -> IDLE on the accepted release.
  - Rotate and select keys never repeat.
- Move arbitration:
  - Fixed priority up > down > left > right. move is never more than one-hot.
  - Losing events in the same cycle are dropped, not queued.
- Select:
  - A sel press event sets sel_idx to sel_idx+1, wrapping from NUM_PIECES-1 to 0.
  - select is the registered one-hot of the new sel_idx, updated in the same cycle as sel_idx.
- Collision rule: in a cycle where a sel event occurs, rotate and move are forced to 0. This prevents a stray step landing on either piece.
- rotate and move may coincide; both are asserted.
- Latency: raw edge to strobe = 2 (sync) + DEB_CYCLES + 1 cycles. All outputs are registered.
- Width rules:
  - Debounce counter: clog2(DEB_CYCLES) bits.
  - Repeat counter: clog2(max(REPEAT_DELAY, REPEAT_PERIOD)) bits.
  - Comparisons use unsigned full-width constants.

Decomposition:
- Package tangram_pkg holds:
  - direction bit indices MV_UP=0, MV_DOWN=1, MV_LEFT=2, MV_RIGHT=3;
  - NUM_PIECES;
  - default timing constants;
  - repeat FSM state enum {RP_IDLE, RP_DELAY, RP_REPEAT}.
- One sub-module, tangram_key_debounce:
  - contains synchronizer, polarity normalise, debounce, press pulse, and optional repeat FSM (parameter REPEAT_EN);
  - instantiated six times, with REPEAT_EN=1 for the four move keys.
- The top level holds arbitration, select counter and output registers.

Test Plan:
- All tests use DEB_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=5, KEY_ACTIVE_LOW=1.
- Reset: hold rst_n=0 with key_up=0 (pressed), then release -> select=7'b0000001, move=0 until key_up has been stable for 4 cycles post-reset. Then exactly one move=4'b0001 pulse.
- Bounce: toggle key_left with 2-cycle glitches for 30 cycles, then hold pressed -> no pulse during glitching. Exactly one move=4'b0100 pulse, 2+4+1 cycles after the last edge.
- Auto-repeat: hold key_right for 60 cycles after acceptance -> pulses at t=0, 20, 25, 30, ... 55, each one cycle wide. None after release.
- Priority: press key_down and key_right in the same cycle -> single move=4'b0010 pulse. No right pulse is emitted later for that press.
- Select wrap: 7 key_sel presses -> sel_idx 1..6 then 0, with select one-hot tracking. Rotate pressed in the same cycle as the 3rd select event produces no rotate pulse.
- Rotate: hold key_rot for 100 cycles -> exactly one rotate pulse, no repeat.
